video_scale_sched: RTL and testbench

- Time-shares one video_scale_process instance between CH_NUM input channels of the stitching pipeline, one whole frame at a time.
- Chooses a requesting channel by round-robin and drives the scaler's size configuration for that channel.
- Issues the scaler's active-low frame sync, then counts the scaled output pixels until the frame is complete.
- Reports per-frame completion, and errors, to the frame-buffer writer.

---
 rtl/video_scale_sched.sv | 269 ++++++++++++++++++++++++++
 tb/tb_video_scale_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_scale_sched.sv
// video_scale_sched: time-shares one video scaler between CH_NUM input
// channels, one whole frame per grant. A round-robin arbiter picks the next
// requesting channel, its size configuration is latched and checked, the
// scaler receives an active-low frame sync, and the scaled output beats are
// counted until the frame is complete. Completion and errors are reported
// with the channel index to the frame-buffer writer.
//
// Optional feature: define SCALE_TIMEOUT_EN to abort a frame that shows no
// counted output beat for TIMEOUT_CYCLES consecutive cycles. The abort
// reports frame_err and then flushes the scaler with an extra sync pulse.
module video_scale_sched #(
  parameter int CH_NUM         = 4,
  parameter int SYNC_LEN       = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                  video_clk,
  input  logic                  rst,
  input  logic [CH_NUM-1:0]     ch_req,
  input  logic [64*CH_NUM-1:0]  ch_cfg,
  output logic [CH_NUM-1:0]     ch_grant,
  output logic                  scl_frame_sync_n,
  output logic [15:0]           scl_width_in,
  output logic [15:0]           scl_height_in,
  output logic [15:0]           scl_width_out,
  output logic [15:0]           scl_height_out,
  input  logic                  scl_out_valid,
  input  logic                  scl_ready,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic [2:0]            done_ch,
  output logic                  busy
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ARB   = 3'd1;
  localparam logic [2:0] CFG   = 3'd2;
  localparam logic [2:0] SYNC  = 3'd3;
  localparam logic [2:0] RUN   = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
`ifdef SCALE_TIMEOUT_EN
  localparam logic [2:0] FLUSH = 3'd6;
`endif

  // Sync-length counter only needs to reach SYNC_LEN-1.
  localparam int SC_W = $clog2(SYNC_LEN);

  logic [2:0]          r_state;
  logic [2:0]          r_ptr;
  logic [2:0]          r_chan;
  logic [CH_NUM-1:0]   r_grant;
  logic                r_sync_n;
  logic [SC_W-1:0]     r_sync_cnt;
  logic [15:0]         r_wi;
  logic [15:0]         r_hi;
  logic [15:0]         r_wo;
  logic [15:0]         r_ho;
  logic [15:0]         r_out_x;
  logic [15:0]         r_out_y;
  logic                r_done;
  logic                r_err;
  logic [2:0]          r_done_ch;

  logic [7:0]          w_req8;
  logic [3:0]          w_idx;
  logic                w_found;
  logic [2:0]          w_sel;
  logic [2:0]          w_ptr_next;
  logic [63:0]         w_cfg_arr [8];
  logic [63:0]         w_sel_cfg;
  logic                w_any_req;
  logic                w_cfg_err;
  logic                w_sync_end;
  logic                w_beat;
  logic                w_x_last;
  logic                w_y_last;
  logic                w_frame_end;
  logic                w_timeout;

  // Per-channel configuration words, padded to 8 entries so the selected
  // channel index can address them directly.
  for (genvar g = 0; g < 8; g++) begin : g_cfg
    if (g < CH_NUM) begin : g_used
      assign w_cfg_arr[g] = ch_cfg[64*g +: 64];
    end else begin : g_pad
      assign w_cfg_arr[g] = '0;
    end
  end

  assign w_req8     = 8'(ch_req);
  assign w_any_req  = |ch_req;
  assign w_sel_cfg  = w_cfg_arr[w_sel];
  assign w_ptr_next = (w_sel == 3'(CH_NUM - 1)) ? 3'd0 : w_sel + 3'd1;

  // Round-robin search: first requesting channel at or after the pointer.
  always_comb begin
    w_found = 1'b0;
    w_sel   = 3'd0;
    w_idx   = 4'd0;
    for (int k = 0; k < CH_NUM; k++) begin
      w_idx = {1'b0, r_ptr} + 4'(k);
      if (w_idx >= 4'(CH_NUM)) begin
        w_idx = w_idx - 4'(CH_NUM);
      end
      if (!w_found && w_req8[w_idx[2:0]]) begin
        w_found = 1'b1;
        w_sel   = w_idx[2:0];
      end
    end
  end

  assign w_cfg_err   = (r_wi == 16'd0) || (r_hi == 16'd0) ||
                       (r_wo == 16'd0) || (r_ho == 16'd0);
  assign w_sync_end  = (r_sync_cnt == SC_W'(SYNC_LEN - 1));
  assign w_beat      = (r_state == RUN) && scl_out_valid && scl_ready;
  assign w_x_last    = (r_out_x == r_wo - 16'd1);
  assign w_y_last    = (r_out_y == r_ho - 16'd1);
  assign w_frame_end = w_beat && w_x_last && w_y_last;

`ifdef SCALE_TIMEOUT_EN
  logic [31:0] r_idle_cnt;

  assign w_timeout = (r_state == RUN) && !w_beat &&
                     (r_idle_cnt == 32'(TIMEOUT_CYCLES - 1));

  // Idle counter: consecutive RUN cycles without a counted output beat.
  always_ff @(posedge video_clk) begin
    if (rst) begin
      r_idle_cnt <= 32'd0;
    end else if (r_state != RUN || w_beat) begin
      r_idle_cnt <= 32'd0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 32'd1;
    end
  end
`else
  logic w_unused_tmo;

  assign w_timeout    = 1'b0;
  assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

  // Frame sequencing state machine.
  always_ff @(posedge video_clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: if (w_any_req) r_state <= ARB;
        ARB:  r_state <= w_found ? CFG : IDLE;
        CFG: begin
          if (w_cfg_err) begin
            r_state <= w_any_req ? ARB : IDLE;
          end else begin
            r_state <= SYNC;
          end
        end
        SYNC: if (w_sync_end) r_state <= RUN;
        RUN: begin
          if (w_frame_end) begin
            r_state <= DONE;
          end
`ifdef SCALE_TIMEOUT_EN
          else if (w_timeout) begin
            r_state <= FLUSH;
          end
`endif
        end
        DONE: r_state <= w_any_req ? ARB : IDLE;
`ifdef SCALE_TIMEOUT_EN
        FLUSH: if (w_sync_end) r_state <= w_any_req ? ARB : IDLE;
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  // Grant, round-robin pointer and the completion/error report pulses.
  always_ff @(posedge video_clk) begin
    if (rst) begin
      r_grant   <= '0;
      r_ptr     <= 3'd0;
      r_chan    <= 3'd0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_done_ch <= 3'd0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (r_state == ARB && w_found) begin
        r_grant <= CH_NUM'(8'd1 << w_sel);
        r_chan  <= w_sel;
        r_ptr   <= w_ptr_next;
      end else if (r_state == CFG && w_cfg_err) begin
        r_err     <= 1'b1;
        r_done_ch <= r_chan;
        r_grant   <= '0;
      end else if (w_frame_end) begin
        r_done    <= 1'b1;
        r_done_ch <= r_chan;
      end else if (w_timeout) begin
        r_err     <= 1'b1;
        r_done_ch <= r_chan;
        r_grant   <= '0;
      end else if (r_state == DONE) begin
        r_grant <= '0;
      end
    end
  end

  // Size registers: loaded only in the arbitration cycle, stable otherwise.
  always_ff @(posedge video_clk) begin
    if (rst) begin
      r_wi <= 16'd0;
      r_hi <= 16'd0;
      r_wo <= 16'd0;
      r_ho <= 16'd0;
    end else if (r_state == ARB && w_found) begin
      r_wi <= w_sel_cfg[63:48];
      r_hi <= w_sel_cfg[47:32];
      r_wo <= w_sel_cfg[31:16];
      r_ho <= w_sel_cfg[15:0];
    end
  end

  // Active-low frame sync: SYNC_LEN cycles before RUN, and as a flush
  // after a timeout abort. The release edge loads the scaler coefficients.
  always_ff @(posedge video_clk) begin
    if (rst) begin
      r_sync_n   <= 1'b1;
      r_sync_cnt <= '0;
    end else if ((r_state == CFG && !w_cfg_err) || w_timeout) begin
      r_sync_n   <= 1'b0;
      r_sync_cnt <= '0;
    end else if (!r_sync_n) begin
      if (w_sync_end) begin
        r_sync_n <= 1'b1;
      end else begin
        r_sync_cnt <= r_sync_cnt + SC_W'(1);
      end
    end
  end

  // Output raster position: cleared during sync, advanced on counted beats.
  always_ff @(posedge video_clk) begin
    if (r_state == SYNC) begin
      r_out_x <= 16'd0;
      r_out_y <= 16'd0;
    end else if (w_beat) begin
      if (w_x_last) begin
        r_out_x <= 16'd0;
        r_out_y <= r_out_y + 16'd1;
      end else begin
        r_out_x <= r_out_x + 16'd1;
      end
    end
  end

  assign ch_grant         = r_grant;
  assign scl_frame_sync_n = r_sync_n;
  assign scl_width_in     = r_wi;
  assign scl_height_in    = r_hi;
  assign scl_width_out    = r_wo;
  assign scl_height_out   = r_ho;
  assign frame_done       = r_done;
  assign frame_err        = r_err;
  assign done_ch          = r_done_ch;
  assign busy             = (r_state != IDLE);

endmodule

// File: tb/tb_video_scale_sched.sv
// Testbench for video_scale_sched: directed frames with a scoreboard queue of
// expected completion/error reports, checked by an independent monitor.
module tb_video_scale_sched;

  localparam int CH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   ch_req;
  logic [64*CH-1:0] ch_cfg;
  logic [CH-1:0]   ch_grant;
  logic            scl_frame_sync_n;
  logic [15:0]     scl_width_in;
  logic [15:0]     scl_height_in;
  logic [15:0]     scl_width_out;
  logic [15:0]     scl_height_out;
  logic            scl_out_valid;
  logic            scl_ready;
  logic            frame_done;
  logic            frame_err;
  logic [2:0]      done_ch;
  logic            busy;

  typedef struct packed {
    logic       err;
    logic [2:0] ch;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  video_scale_sched #(
    .CH_NUM(CH),
    .SYNC_LEN(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .video_clk(clk),
    .rst(rst),
    .ch_req(ch_req),
    .ch_cfg(ch_cfg),
    .ch_grant(ch_grant),
    .scl_frame_sync_n(scl_frame_sync_n),
    .scl_width_in(scl_width_in),
    .scl_height_in(scl_height_in),
    .scl_width_out(scl_width_out),
    .scl_height_out(scl_height_out),
    .scl_out_valid(scl_out_valid),
    .scl_ready(scl_ready),
    .frame_done(frame_done),
    .frame_err(frame_err),
    .done_ch(done_ch),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_cfg(input logic [15:0] wi, input logic [15:0] hi,
                                         input logic [15:0] wo, input logic [15:0] ho);
    return {wi, hi, wo, ho};
  endfunction

  // Monitor: every reported event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (frame_done || frame_err) begin
      total++;
      if (frame_done && frame_err) begin
        bad++;
        $display("FAIL report_overlap: done=1 err=1 ch=%0d, expected only one", done_ch);
      end else if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_report: done=%0b err=%0b ch=%0d, expected none", frame_done, frame_err, done_ch);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.err !== frame_err || mon_e.ch !== done_ch) begin
          bad++;
          $display("FAIL report: got err=%0b ch=%0d expected err=%0b ch=%0d", frame_err, done_ch, mon_e.err, mon_e.ch);
        end
      end
    end
  end

  // Wait (bounded) for sync to go low, check grant, then measure low length.
  task automatic wait_sync(input logic [CH-1:0] exp_grant, input int bound);
    int w;
    int len;
    w = 0;
    while (scl_frame_sync_n !== 1'b0 && w < bound) begin
      @(negedge clk);
      w++;
    end
    chk("sync_seen", {63'd0, scl_frame_sync_n}, 64'd0);
    chk("grant", 64'(ch_grant), 64'(exp_grant));
    len = 0;
    while (scl_frame_sync_n === 1'b0 && len < 20) begin
      len++;
      @(negedge clk);
    end
    chk("sync_len", 64'(len), 64'd4);
  endtask

  // Drive output beats; with tog set, ready is high only on alternate cycles.
  task automatic feed(input int n, input bit tog);
    int  cnt;
    int  cyc;
    logic r;
    cnt = 0;
    cyc = 0;
    while (cnt < n && cyc < 200) begin
      r = tog ? (cyc % 2 == 0) : 1'b1;
      scl_out_valid = 1'b1;
      scl_ready     = r;
      @(posedge clk);
      if (r) cnt++;
      cyc++;
      @(negedge clk);
      if (cnt < n) chk("no_early_done", {63'd0, frame_done}, 64'd0);
    end
    scl_out_valid = 1'b0;
    scl_ready     = 1'b1;
    chk("beats_fed", 64'(cnt), 64'(n));
    chk("done_latency", {63'd0, frame_done}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_low;
    rst           = 1'b1;
    ch_req        = '0;
    ch_cfg        = '0;
    scl_out_valid = 1'b0;
    scl_ready     = 1'b1;

    // Reset and idle
    repeat (3) begin
      @(negedge clk);
      chk("rst_grant", 64'(ch_grant), 64'd0);
      chk("rst_sync_n", {63'd0, scl_frame_sync_n}, 64'd1);
      chk("rst_sizes", {scl_width_in, scl_height_in, scl_width_out, scl_height_out}, 64'd0);
      chk("rst_pulses", {61'd0, frame_done, frame_err, busy}, 64'd0);
      chk("rst_done_ch", 64'(done_ch), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", {63'd0, busy}, 64'd0);
    chk("idle_sync_n", {63'd0, scl_frame_sync_n}, 64'd1);

    // Single frame on ch0: 8x4 -> 4x2, 8 output beats
    ch_cfg[63:0] = mk_cfg(16'd8, 16'd4, 16'd4, 16'd2);
    ch_req = 4'b0001;
    exp_q.push_back('{err: 1'b0, ch: 3'd0});
    @(negedge clk);
    chk("lat_sync_c1", {63'd0, scl_frame_sync_n}, 64'd1);
    chk("busy_arb", {63'd0, busy}, 64'd1);
    @(negedge clk);
    chk("lat_sync_c2", {63'd0, scl_frame_sync_n}, 64'd1);
    chk("single_grant", 64'(ch_grant), 64'd1);
    chk("single_sizes", {scl_width_in, scl_height_in, scl_width_out, scl_height_out},
        mk_cfg(16'd8, 16'd4, 16'd4, 16'd2));
    @(negedge clk);
    chk("lat_sync_c3", {63'd0, scl_frame_sync_n}, 64'd0);
    ch_req = 4'b0000;
    wait_sync(4'b0001, 2);
    feed(8, 1'b0);

    // Round-robin from a freshly reset pointer, 2x2 output frames
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < CH; c++) ch_cfg[64*c +: 64] = mk_cfg(16'd4, 16'd4, 16'd2, 16'd2);
    ch_req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back('{err: 1'b0, ch: 3'(i % CH)});
      wait_sync(4'(1 << (i % CH)), 20);
      if (i == 4) ch_req = 4'b0000;
      feed(4, 1'b0);
    end

    // Backpressure: pointer now at ch1, ready toggling
    ch_req = 4'b0010;
    exp_q.push_back('{err: 1'b0, ch: 3'd1});
    wait_sync(4'b0010, 20);
    ch_req = 4'b0000;
    feed(4, 1'b1);

    // Zero output width on ch2 is rejected without a sync pulse
    ch_cfg[191:128] = mk_cfg(16'd4, 16'd4, 16'd0, 16'd2);
    @(negedge clk);
    ch_req = 4'b0100;
    exp_q.push_back('{err: 1'b1, ch: 3'd2});
    saw_low = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (scl_frame_sync_n === 1'b0) saw_low = 1'b1;
      if (i == 2) ch_req = 4'b0000;
    end
    chk("err_no_sync", {63'd0, saw_low}, 64'd0);
    chk("err_grant_clr", 64'(ch_grant), 64'd0);
    chk("err_back_idle", {63'd0, busy}, 64'd0);
    ch_cfg[191:128] = mk_cfg(16'd4, 16'd4, 16'd2, 16'd2);

`ifdef SCALE_TIMEOUT_EN
    // Timeout on ch0, flush sync, then ch1 is served
    ch_req = 4'b0011;
    exp_q.push_back('{err: 1'b1, ch: 3'd0});
    exp_q.push_back('{err: 1'b0, ch: 3'd1});
    wait_sync(4'b0001, 20);
    ch_req = 4'b0010;
    wait_sync(4'b0000, 40);
    wait_sync(4'b0010, 20);
    ch_req = 4'b0000;
    feed(4, 1'b0);
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("final_idle", {63'd0, busy}, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
